prog_counter_stack: RTL

PROG_COUNTER_STACK -- requirements
Module: prog_counter_stack

---
 rtl/prog_counter_stack_if.sv | 32 +++
 rtl/prog_counter_stack.sv | 99 +++++++++
 2 files changed

// File: rtl/prog_counter_stack_if.sv
// Command/status bundle for the program counter with return-address stack.
// The controller side (master) issues PC commands; the counter (slave)
// reports the current PC and the stack status.
interface prog_counter_stack_if #(
  parameter int ADDR_W      = 6,
  parameter int STACK_DEPTH = 4
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic              ce;
  logic              clear_PC;
  logic              load_PC;
  logic              call_PC;
  logic              ret_PC;
  logic              enable_PC;
  logic [ADDR_W-1:0] ADR_IN;
  logic [ADDR_W-1:0] ADR_OUT;
  logic [LVL_W-1:0]  stack_level;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_err;

  modport master (
    output ce, clear_PC, load_PC, call_PC, ret_PC, enable_PC, ADR_IN,
    input  ADR_OUT, stack_level, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  ce, clear_PC, load_PC, call_PC, ret_PC, enable_PC, ADR_IN,
    output ADR_OUT, stack_level, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/prog_counter_stack.sv
// Program counter with a small LIFO of return addresses.
// One command per enabled edge, fixed priority clear > load > call > ret > inc.
// Overflowing or underflowing the stack is a no-op that raises a sticky error.
module prog_counter_stack #(
  parameter int ADDR_W      = 6,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0
) (
  input logic                   clk,
  input logic                   rst,
  prog_counter_stack_if.slave   bus
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_ADDR);
  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [LVL_W-1:0]  level_reg, level_next;
  logic              err_reg, err_next;
  logic              push_en;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] ret_addr;
  logic [PTR_W-1:0]  push_idx;
  logic              is_full, is_empty;

  // Entry storage: small register file, read combinationally so a return
  // completes in a single edge. Entries above the level are never read.
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  assign pc_inc   = pc_reg + ADDR_W'(1);
  assign is_full  = (level_reg == FULL_LVL);
  assign is_empty = (level_reg == '0);
  assign push_idx = level_reg[PTR_W-1:0];

  // Select the top-of-stack entry (index level-1) as the return target.
  always_comb begin
    ret_addr = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (level_reg == LVL_W'(i + 1)) ret_addr = stack_mem[i];
    end
  end

  // Priority command decode producing next PC, level, error and push strobe.
  always_comb begin
    pc_next    = pc_reg;
    level_next = level_reg;
    err_next   = err_reg;
    push_en    = 1'b0;
    if (bus.ce) begin
      if (bus.clear_PC) begin
        pc_next = RESET_PC;
      end else if (bus.load_PC) begin
        pc_next = bus.ADR_IN;
      end else if (bus.call_PC) begin
        if (is_full) begin
          err_next = 1'b1;
        end else begin
          push_en    = 1'b1;
          level_next = level_reg + LVL_W'(1);
          pc_next    = bus.ADR_IN;
        end
      end else if (bus.ret_PC) begin
        if (is_empty) begin
          err_next = 1'b1;
        end else begin
          level_next = level_reg - LVL_W'(1);
          pc_next    = ret_addr;
        end
      end else if (bus.enable_PC) begin
        pc_next = pc_inc;
      end
    end
  end

  // PC, stack level and sticky error registers; reset discards the stack.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      level_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      level_reg <= level_next;
      err_reg   <= err_next;
    end
  end

  // Push the return address (PC+1, wrapping) into the slot at the current level.
  always_ff @(posedge clk) begin
    if (!rst && push_en) stack_mem[push_idx] <= pc_inc;
  end

  assign bus.ADR_OUT     = pc_reg;
  assign bus.stack_level = level_reg;
  assign bus.stack_full  = is_full;
  assign bus.stack_empty = is_empty;
  assign bus.stack_err   = err_reg;
endmodule
